// File: rtl/nvram_upload_reader.sv
// Read side of the HPS ioctl upload channel. It pauses the CPU, then serves NVRAM
// nibbles as bytes (upper bits forced high) and tracks whether NVRAM is dirty.
module nvram_upload_reader #(
  parameter int AW      = 10,
  parameter int DW      = 4,
  parameter int RAM_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_q,
  input  logic          cpu_nv_we,
  output logic          nv_dirty,
  output logic          busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAUSE   = 3'd1;
  localparam logic [2:0] S_READY   = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [1:0] LAT       = 2'(RAM_LAT);

  logic [2:0]    r_state;
  logic          r_upload_d;
  logic [1:0]    r_cnt;
  logic          r_served;
  logic [7:0]    r_din;
  logic          r_wait;
  logic          r_pause;
  logic          r_busy;
  logic          r_dirty;
  logic          r_ram_rd;
  logic [AW-1:0] r_ram_addr;

  logic          w_in_range;
  logic          w_abort;
  logic          w_clear;
  logic          w_set;
  logic [7:0]    w_byte;

  // Only addresses below 2**AW reach the RAM; anything above reads as erased (FF).
  assign w_in_range = (ioctl_addr[24:AW] == '0);
  assign w_abort    = (r_state != S_IDLE) && !ioctl_upload;
  assign w_clear    = w_abort && r_served;
  assign w_set      = cpu_nv_we && !pause_ack;

  always_comb begin
    w_byte            = '1;
    w_byte[DW-1:0]    = ram_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_upload_d <= 1'b0;
      r_cnt      <= '0;
      r_served   <= 1'b0;
      r_din      <= 8'hFF;
      r_wait     <= 1'b0;
      r_pause    <= 1'b0;
      r_busy     <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      r_upload_d <= ioctl_upload;
      r_ram_rd   <= 1'b0;
      if (w_abort) begin
        r_state  <= S_IDLE;
        r_pause  <= 1'b0;
        r_busy   <= 1'b0;
        r_wait   <= 1'b0;
        r_served <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ioctl_upload && !r_upload_d) begin
              r_state  <= S_PAUSE;
              r_busy   <= 1'b1;
              r_pause  <= 1'b1;
              r_wait   <= 1'b1;
              r_served <= 1'b0;
            end
          end
          S_PAUSE: begin
            if (pause_ack) begin
              r_state <= S_READY;
              r_wait  <= 1'b0;
            end
          end
          // PRESENT already has wait low, so a strobe arriving there is served too.
          S_READY, S_PRESENT: begin
            r_wait  <= 1'b0;
            r_state <= S_READY;
            if (ioctl_rd) begin
              r_served <= 1'b1;
              if (w_in_range) begin
                r_ram_addr <= ioctl_addr[AW-1:0];
                r_ram_rd   <= 1'b1;
                r_wait     <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_FETCH;
              end else begin
                r_din <= 8'hFF;
              end
            end
          end
          S_FETCH: begin
            if (r_cnt == LAT) begin
              r_din   <= w_byte;
              r_wait  <= 1'b0;
              r_state <= S_PRESENT;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // A CPU write in the same cycle as the upload-complete clear keeps the flag set.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty <= 1'b0;
    end else if (w_set) begin
      r_dirty <= 1'b1;
    end else if (w_clear) begin
      r_dirty <= 1'b0;
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign pause_req  = r_pause;
  assign busy       = r_busy;
  assign nv_dirty   = r_dirty;
  assign ram_rd     = r_ram_rd;
  assign ram_addr   = r_ram_addr;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Bench for nvram_upload_reader: three instances with RAM_LAT 1, 2 and 3 share
// the hps_io-side stimulus; each has its own latency-accurate RAM model.
module tb_nvram_upload_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upload;
  logic        rd;
  logic [24:0] addr;
  logic        ack;
  logic        we;

  logic [7:0] din   [3];
  logic       wt    [3];
  logic       preq  [3];
  logic [9:0] raddr [3];
  logic       rrd   [3];
  logic [3:0] rq    [3];
  logic       dirty [3];
  logic       bsy   [3];

  logic [3:0] mem [1024];

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_dirty = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [3:0] pipe [3];
    nvram_upload_reader #(.AW(10), .DW(4), .RAM_LAT(g + 1)) dut (
      .clk_sys      (clk),
      .reset_n      (rst_n),
      .ioctl_upload (upload),
      .ioctl_rd     (rd),
      .ioctl_addr   (addr),
      .ioctl_din    (din[g]),
      .ioctl_wait   (wt[g]),
      .pause_req    (preq[g]),
      .pause_ack    (ack),
      .ram_addr     (raddr[g]),
      .ram_rd       (rrd[g]),
      .ram_q        (rq[g]),
      .cpu_nv_we    (we),
      .nv_dirty     (dirty[g]),
      .busy         (bsy[g])
    );
    // Data is valid exactly RAM_LAT cycles after the read strobe, zero otherwise.
    always @(posedge clk) begin
      pipe[0] <= rrd[g] ? mem[raddr[g]] : 4'h0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rq[g] = pipe[g];
  end

  function automatic logic [7:0] model_byte(input logic [24:0] a);
    if (a < 25'd1024) return {4'hF, mem[a[9:0]]};
    return 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; upload = 1'b0; rd = 1'b0; addr = '0; ack = 1'b0; we = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_dirty = 1'b0;
  endtask

  task automatic open_session();
    upload = 1'b1;
    tick();
    ack = 1'b1;
    tick();
  endtask

  task automatic close_session();
    upload = 1'b0; ack = 1'b0;
    tick(); tick();
  endtask

  // Issues one read and checks every DUT cycle by cycle until all are idle again.
  task automatic one_read(input logic [24:0] a, input string tag);
    bit inr;
    logic [7:0] exp;
    inr = (a < 25'd1024);
    exp = model_byte(a);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (wt[g] !== (inr && (k <= g + 1))) begin
          n_fail++;
          $display("FAIL %s_wait L%0d k%0d a=%h got %b want %b", tag, g + 1, k, a, wt[g], inr && (k <= g + 1));
        end
        n_checks++;
        if (rrd[g] !== (inr && k == 0)) begin
          n_fail++;
          $display("FAIL %s_ram_rd L%0d k%0d a=%h got %b want %b", tag, g + 1, k, a, rrd[g], inr && k == 0);
        end
        if ((inr && k == g + 2) || (!inr && k == 0)) begin
          n_checks++;
          if (din[g] !== exp) begin
            n_fail++;
            $display("FAIL %s_din L%0d a=%h got %h want %h", tag, g + 1, a, din[g], exp);
          end
        end
        if (inr && k == 0) begin
          n_checks++;
          if (raddr[g] !== a[9:0]) begin
            n_fail++;
            $display("FAIL %s_ram_addr L%0d got %h want %h", tag, g + 1, raddr[g], a[9:0]);
          end
        end
      end
      if (k < 5) tick();
    end
  endtask

  task automatic check_dirty(input string tag);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (dirty[g] !== exp_dirty) begin
        n_fail++;
        $display("FAIL %s L%0d nv_dirty got %b want %b", tag, g + 1, dirty[g], exp_dirty);
      end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({din[g], wt[g], preq[g], bsy[g], dirty[g], rrd[g], raddr[g]} !== {8'hFF, 5'b0, 10'h0}) begin
        n_fail++;
        $display("FAIL reset_values L%0d got din=%h wait=%b preq=%b busy=%b dirty=%b rd=%b addr=%h want FF/0",
                 g + 1, din[g], wt[g], preq[g], bsy[g], dirty[g], rrd[g], raddr[g]);
      end
    end
    mem[10'h055] = 4'h3;
    open_session();
    rd = 1'b1; addr = 25'h55;
    tick();
    rd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({preq[g], bsy[g], wt[g], rrd[g], din[g]} !== {4'b0, 8'hFF}) begin
        n_fail++;
        $display("FAIL reset_async L%0d got preq=%b busy=%b wait=%b rd=%b din=%h want 0/0/0/0/FF",
                 g + 1, preq[g], bsy[g], wt[g], rrd[g], din[g]);
      end
    end
    upload = 1'b0; ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({bsy[g], preq[g], din[g]} !== {2'b0, 8'hFF}) begin
        n_fail++;
        $display("FAIL reset_idle L%0d got busy=%b preq=%b din=%h want 0/0/FF", g + 1, bsy[g], preq[g], din[g]);
      end
    end
  endtask

  task automatic test_handshake();
    upload = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bsy[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL hs_busy_early L%0d got %b want 0", g + 1, bsy[g]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if ({bsy[g], preq[g], wt[g]} !== 3'b111) begin
          n_fail++;
          $display("FAIL hs_pause L%0d c%0d got busy/preq/wait=%b%b%b want 111", g + 1, c, bsy[g], preq[g], wt[g]);
        end
      end
    end
    ack = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({bsy[g], preq[g], wt[g]} !== 3'b110) begin
        n_fail++;
        $display("FAIL hs_ready L%0d got busy/preq/wait=%b%b%b want 110", g + 1, bsy[g], preq[g], wt[g]);
      end
    end
    upload = 1'b0; ack = 1'b0;
    tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({bsy[g], preq[g], wt[g]} !== 3'b000) begin
        n_fail++;
        $display("FAIL hs_close L%0d got busy/preq/wait=%b%b%b want 000", g + 1, bsy[g], preq[g], wt[g]);
      end
    end
    tick();
    check_dirty("hs_no_bytes_dirty");
  endtask

  task automatic test_read();
    mem[10'h123] = 4'hA;
    open_session();
    one_read(25'h123, "read");
    close_session();
  endtask

  task automatic test_oor();
    mem[10'h001] = 4'h2;
    open_session();
    one_read(25'h001, "oor_pre");
    one_read(25'h400, "oor_400");
    one_read(25'h001, "oor_mid");
    one_read(25'h400 + 25'($urandom_range(0, 25'h1FFFBFF)), "oor_rnd");
    close_session();
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    we = 1'b1;
    tick();
    we = 1'b0;
    exp_dirty = 1'b1;
    check_dirty("sweep_dirty_set");
    open_session();
    for (int a = 0; a < 1024; a++) begin
      rd = 1'b1; addr = 25'(a);
      tick();
      rd = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (din[g] !== model_byte(25'(a)) || wt[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep L%0d a=%h got din=%h wait=%b want din=%h wait=0",
                   g + 1, a, din[g], wt[g], model_byte(25'(a)));
        end
      end
    end
    upload = 1'b0; ack = 1'b0;
    tick();
    exp_dirty = 1'b0;
    check_dirty("sweep_dirty_clear");
  endtask

  task automatic test_dirty();
    open_session();
    one_read(25'h010, "dirty_rd");
    we = 1'b1;
    tick();
    we = 1'b0;
    check_dirty("dirty_we_paused");
    upload = 1'b0; ack = 1'b0; we = 1'b1;
    tick();
    we = 1'b0;
    exp_dirty = 1'b1;
    check_dirty("dirty_race");
    tick();
    upload = 1'b1;
    tick(); tick();
    upload = 1'b0;
    tick(); tick();
    check_dirty("dirty_no_ack");
    open_session();
    close_session();
    check_dirty("dirty_no_bytes");
    open_session();
    one_read(25'h3FF, "dirty_rd2");
    upload = 1'b0; ack = 1'b0;
    tick();
    exp_dirty = 1'b0;
    check_dirty("dirty_clear");
    tick();
  endtask

  task automatic test_random();
    logic [24:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    open_session();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) a = 25'($urandom_range(0, 1023));
      else a = 25'($urandom_range(1024, 25'h1FFFFFF));
      one_read(a, "rand");
    end
    close_session();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_handshake();
    test_read();
    test_oor();
    test_sweep();
    test_dirty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
